match_event_recorder: RTL

- Downstream consumer of the serial pattern detector's one-cycle match pulse.
- Timestamps each match with a free-running bit-position counter and buffers the events in a small first-word-fall-through FIFO.
- Drains the events over a valid/ready interface to a host or logger.
- Keeps saturating total-match and dropped-event counters, plus a sticky overflow flag.

---
 rtl/match_event_recorder_pkg.sv | 17 +
 rtl/match_event_recorder_if.sv | 16 +
 rtl/match_event_recorder_fifo.sv | 68 ++++++
 rtl/match_event_recorder.sv | 102 ++++++++++
 4 files changed

// File: rtl/match_event_recorder_pkg.sv
// Shared definitions for the pattern-detector slice.
//   IDX_W_DEF / CNT_W_DEF : default widths of bit index and event counters.
//   sat_inc               : saturating increment of a value of width w (w <= 32).
package match_event_recorder_pkg;

  localparam int unsigned IDX_W_DEF = 16;
  localparam int unsigned CNT_W_DEF = 16;

  // Counter values are passed zero-extended to 32 bits; the result never
  // exceeds the all-ones value of width w, so callers can truncate safely.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/match_event_recorder_if.sv
// Event drain channel (valid/ready) from the recorder to a host or logger.
//   ev_valid : head entry valid          (master -> slave)
//   ev_idx   : bit position of the head  (master -> slave)
//   ev_ready : consumer accepts the head (slave -> master)
interface match_event_recorder_if
  import match_event_recorder_pkg::*;
#(
  parameter int unsigned IDX_W = IDX_W_DEF
);
  logic             ev_valid;
  logic             ev_ready;
  logic [IDX_W-1:0] ev_idx;

  modport master (output ev_valid, output ev_idx, input ev_ready);
  modport slave  (input ev_valid, input ev_idx, output ev_ready);
endinterface

// File: rtl/match_event_recorder_fifo.sv
// sync_fwft_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst : clock, synchronous active-high reset
//   push_i   : write din_i (ignored when full unless popping in the same cycle)
//   din_i    : write data
//   pop_i    : discard head (ignored when empty)
//   dout_o   : head entry, zero while empty
//   full_o   : DEPTH entries held
//   empty_o  : no entries held
//   level_o  : occupancy, 0..DEPTH
// DEPTH must be a power of two, at least 2.
module sync_fwft_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push, do_pop;

  // Pointers carry one extra lap bit: equal low bits with differing lap bits
  // means full, fully equal means empty.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level_o = wr_q - rd_q;

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Gate the head so stale storage never leaks out while empty.
  assign dout_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + PTR_ONE;
    if (do_pop)  rd_d = rd_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset; contents are only visible through the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/match_event_recorder.sv
// match_event_recorder: timestamps detector match pulses with a free-running
// bit-position counter, buffers them in a FWFT FIFO and drains them over a
// valid/ready channel. Keeps saturating total/drop counters and a sticky
// overflow flag.
//   clk, rst  : clock, synchronous active-high reset
//   bit_en    : detector consumed a serial bit this cycle (advances bit_pos)
//   match     : registered match pulse from the detector
//   ev_if     : event drain channel (ev_valid, ev_idx out; ev_ready in)
//   level     : FIFO occupancy
//   overflow  : sticky, at least one match dropped since the last clear
//   clr_ovf   : clears overflow and drop_cnt (a same-cycle drop wins)
//   total_cnt : all matches seen, saturating
//   drop_cnt  : matches lost to a full FIFO, saturating
module match_event_recorder
  import match_event_recorder_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX_W = IDX_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bit_en,
  input  logic                     match,
  match_event_recorder_if.master   ev_if,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clr_ovf,
  output logic [CNT_W-1:0]         total_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);

  logic [IDX_W-1:0] bit_pos_q, bit_pos_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             ovf_q, ovf_d;

  logic             fifo_full, fifo_empty;
  logic [IDX_W-1:0] fifo_dout;
  logic             pop, push, drop;

  // Full-with-pop frees the slot in the same cycle, so only a full FIFO
  // without a pop loses the event.
  assign pop  = !fifo_empty && ev_if.ev_ready;
  assign push = match && (!fifo_full || pop);
  assign drop = match && fifo_full && !pop;

  sync_fwft_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (bit_pos_q),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign ev_if.ev_valid = !fifo_empty;
  assign ev_if.ev_idx   = fifo_dout;
  assign overflow       = ovf_q;
  assign total_cnt      = total_q;
  assign drop_cnt       = drop_q;

  always_comb begin
    bit_pos_d = bit_pos_q;
    total_d   = total_q;
    drop_d    = drop_q;
    ovf_d     = ovf_q;

    if (bit_en) bit_pos_d = bit_pos_q + IDX_W'(1);
    if (match)  total_d   = CNT_W'(sat_inc(32'(total_q), CNT_W));

    // A drop in the clearing cycle counts against the freshly cleared value.
    if (drop) begin
      ovf_d  = 1'b1;
      drop_d = clr_ovf ? CNT_W'(1) : CNT_W'(sat_inc(32'(drop_q), CNT_W));
    end else if (clr_ovf) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_pos_q <= '0;
      total_q   <= '0;
      drop_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      bit_pos_q <= bit_pos_d;
      total_q   <= total_d;
      drop_q    <= drop_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule
